jtkcpu_busctl: RTL
==================

# jtkcpu_busctl

Bus sequencer between the KCPU control unit and external memory. Accepts one request at a time: opcode fetch, operand fetch, 8/16-bit data read or 8/16-bit data write. Runs it as one or two 8-bit bus cycles and returns the fetched opcode and assembled 16-bit data word. Drives `mem_busy` so the microcode sequencer stalls until the access completes.

## Interface
- `WAITCK`, default 0: extra `cen` cycles inserted in every byte cycle before `bus_ok` is sampled (0–15).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: clock enable; all state advances only when high.
- `pc` in 16: program counter, the address for fetch/opd.
- `ea` in 16: effective address, used for rd/wr.
- `fetch` in 1: opcode fetch request.
- `opd` in 1: operand byte fetch request.
- `rd` in 1: data read request.
- `wr` in 1: data write request (`wrq` from control).
- `wide` in 1: rd/wr is 16-bit (`memhi`).
- `wdata` in 16: write data; the low byte is used when `wide`=0.
- `halt` in 1: blocks acceptance of new requests.
- `op` out 8: last fetched opcode.
- `mdata` out 16: read data shift register.
- `mem_busy` out 1: access in progress.
- `halted` out 1: idle and halt asserted.
- `bus_addr` out 16: bus address.
- `bus_dout` out 8: bus write data.
- `bus_din` in 8: bus read data.
- `bus_cs` out 1: bus cycle active.
- `bus_we` out 1: write strobe.
- `bus_ok` in 1: memory ready.

## Operation
- States: IDLE, WAIT, XFER. A byte counter `last` marks the final byte.
- Acceptance happens in IDLE when `cen`=1, `halt`=0 and any request is high.
  - Priority: `wr` > `fetch` > `opd` > `rd`. Lower requests present at the same time are ignored and must be reissued.
  - The request type, `wide`, the address and `wdata` are latched at acceptance. Later input changes have no effect on the access in flight.
  - `wide` applies to rd/wr only. fetch and opd are always 8-bit.
- Address: fetch/opd use `pc`, rd/wr use `ea`. For a wide access the first byte goes to the latched address (high byte) and the second to address+1 (low byte). Address+1 wraps 16'hFFFF→16'h0000.
- On acceptance: `bus_cs`=1, `bus_we`=wr, `mem_busy`=1.
  - Next state is WAIT with counter=`WAITCK` if `WAITCK`>0; otherwise XFER.
- WAIT: the counter decrements on each `cen`. At 0 the state moves to XFER.
- XFER: the byte completes on a `cen` edge with `bus_ok`=1. With `bus_ok`=0 it holds indefinitely with all outputs stable.
  - Read completion: `mdata <= {mdata[7:0], bus_din}`. A fetch also loads `op <= bus_din`; `mdata` is updated as well.
  - Write completion: `bus_dout` advances from the high byte to the low byte for a wide access.
  - If not last: `bus_addr`+1, re-enter WAIT/XFER for the second byte. `bus_cs` stays high.
  - If last: state IDLE, `bus_cs`=0, `bus_we`=0, `mem_busy`=0.
- After a wide read, `mdata` = {byte@addr, byte@addr+1}. After an 8-bit read, `mdata[7:0]` is the new byte and `mdata[15:8]` is the previous low byte.
- `halted` = IDLE & `halt`. `halt` raised mid-access does not abort the access; `halted` rises after completion.
- Reset (any state, including mid-access): state IDLE, `op`=0, `mdata`=0, `mem_busy`=0, `bus_cs`=0, `bus_we`=0, `bus_addr`=0, `bus_dout`=0, `halted`=0. No partial write completes after reset.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- With `cen`=1, `WAITCK`=0 and `bus_ok`=1:
  - 8-bit access: request sampled at edge E0; `bus_cs`/`mem_busy` rise after E0; data is latched and `mem_busy` falls at E1.
  - 16-bit access: completes at E2.
- Each byte costs `1+WAITCK` cen cycles plus one extra cen cycle per `bus_ok`-low sample in XFER.
- A new request can be accepted on the edge right after `mem_busy` falls. Back-to-back 8-bit accesses use 2 edges each.
- `cen`=0 freezes everything, including the WAIT counter.

## Test plan
- Reset, then fetch with `pc`=16'h1234 and `bus_din`=8'h86 → `bus_addr`=1234, `bus_cs` high 1 cycle; `op`=86, `mem_busy` low at E1.
- Wide read, `ea`=16'hFFFF, bytes 8'hAB then 8'hCD → addresses FFFF then 0000; `mdata`=16'hABCD at E2.
- Wide write, `wdata`=16'h5A3C, `ea`=16'h2000 → `bus_we` high, (2000,5A) then (2001,3C); `mem_busy` low at E2.
- `WAITCK`=2 and `bus_ok` held low 3 cycles on an 8-bit rd → completion at E0+6 edges; outputs stable during the stall.
- wr and fetch both asserted at once → write performed, `op` unchanged. Then `halt` raised mid-access → access completes, `halted`=1 and the pending fetch is not accepted.
- `rst` pulsed during the second byte of a wide write → `bus_cs`/`bus_we`/`mem_busy`=0 next edge, no second-byte write observed.

Source files
------------

// File: rtl/jtkcpu_busctl_if.sv
`default_nettype none
// ============================================================================
// jtkcpu_busctl_if
// Request/response bundle between KCPU control, the bus sequencer and
// external memory. The slave side is the sequencer; the master side drives
// requests and models memory.
// Revision: 1.0 - initial release
// ============================================================================
interface jtkcpu_busctl_if;
  logic        cen;
  logic [15:0] pc;
  logic [15:0] ea;
  logic        fetch;
  logic        opd;
  logic        rd;
  logic        wr;
  logic        wide;
  logic [15:0] wdata;
  logic        halt;
  logic [7:0]  op;
  logic [15:0] mdata;
  logic        mem_busy;
  logic        halted;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_cs;
  logic        bus_we;
  logic        bus_ok;

  modport slave (
    input  cen, pc, ea, fetch, opd, rd, wr, wide, wdata, halt, bus_din, bus_ok,
    output op, mdata, mem_busy, halted, bus_addr, bus_dout, bus_cs, bus_we
  );

  modport master (
    output cen, pc, ea, fetch, opd, rd, wr, wide, wdata, halt, bus_din, bus_ok,
    input  op, mdata, mem_busy, halted, bus_addr, bus_dout, bus_cs, bus_we
  );
endinterface
`default_nettype wire

// File: rtl/jtkcpu_busctl.sv
`default_nettype none
// ============================================================================
// jtkcpu_busctl
// Bus sequencer for the KCPU: runs one fetch/operand/read/write request as
// one or two 8-bit bus cycles, stalling the microcode via mem_busy.
// Revision: 1.0 - initial release
// ============================================================================
module jtkcpu_busctl #(
  parameter int unsigned WAITCK = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  jtkcpu_busctl_if.slave  io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAITCK);
  localparam logic       USE_WAIT  = (WAITCK != 0);

  state_t      st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        fetch_q, fetch_d;
  logic [7:0]  wlo_q, wlo_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] mdata_q, mdata_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;

  // Request decode for the acceptance cycle: wr beats fetch beats opd beats rd.
  logic w_req, w_use_pc, w_wide;
  assign w_req    = io.wr | io.fetch | io.opd | io.rd;
  assign w_use_pc = !io.wr && (io.fetch || io.opd);
  assign w_wide   = io.wide && !w_use_pc;

  // Next-state logic; everything holds while cen is low.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    fetch_d  = fetch_q;
    wlo_d    = wlo_q;
    op_d     = op_q;
    mdata_d  = mdata_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    cs_d     = cs_q;
    we_d     = we_q;
    if (io.cen) begin
      case (st_q)
        ST_IDLE: begin
          if (!io.halt && w_req) begin
            addr_d  = w_use_pc ? io.pc : io.ea;
            we_d    = io.wr;
            cs_d    = 1'b1;
            busy_d  = 1'b1;
            fetch_d = !io.wr && io.fetch;
            last_d  = !w_wide;
            wlo_d   = io.wdata[7:0];
            if (io.wr) begin
              dout_d = w_wide ? io.wdata[15:8] : io.wdata[7:0];
            end
            st_d  = USE_WAIT ? ST_WAIT : ST_XFER;
            cnt_d = WAIT_INIT;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            st_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (io.bus_ok) begin
            if (!we_q) begin
              mdata_d = {mdata_q[7:0], io.bus_din};
              if (fetch_q) begin
                op_d = io.bus_din;
              end
            end
            if (last_q) begin
              st_d   = ST_IDLE;
              cs_d   = 1'b0;
              we_d   = 1'b0;
              busy_d = 1'b0;
            end else begin
              // Second byte of a wide access goes to address+1 (wraps at FFFF).
              addr_d = addr_q + 16'd1;
              last_d = 1'b1;
              if (we_q) begin
                dout_d = wlo_q;
              end
              st_d  = USE_WAIT ? ST_WAIT : ST_XFER;
              cnt_d = WAIT_INIT;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
      halted_d = (st_d == ST_IDLE) && io.halt;
    end
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      fetch_q  <= 1'b0;
      wlo_q    <= 8'h00;
      op_q     <= 8'h00;
      mdata_q  <= 16'h0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      addr_q   <= 16'h0000;
      dout_q   <= 8'h00;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      fetch_q  <= fetch_d;
      wlo_q    <= wlo_d;
      op_q     <= op_d;
      mdata_q  <= mdata_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
    end
  end

  assign io.op       = op_q;
  assign io.mdata    = mdata_q;
  assign io.mem_busy = busy_q;
  assign io.halted   = halted_q;
  assign io.bus_addr = addr_q;
  assign io.bus_dout = dout_q;
  assign io.bus_cs   = cs_q;
  assign io.bus_we   = we_q;

endmodule
`default_nettype wire
